half_pel_row_collector: RTL and testbench
=========================================

# half_pel_row_collector

Writer side of the half-pel row buffers. Accepts 120-bit filtered rows from the horizontal/vertical interpolation filter through a valid/ready handshake and packs them in order into three 960-bit half-sample arrays (A, B, C). These arrays drive the input row multiplexer's half-pel inputs. Once all 3×NUM_PIXEL rows are captured, the block presents the arrays as stable and holds them until the consumer acknowledges.

## Interface
Parameters:
- NUM_PIXEL, 8, rows per half-pel array (block width)
- ROW_W, 120, bits per row (15 samples × 8 bits)

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  filter row valid
- in_ready  out  1  collector can accept a row
- in_row  in  ROW_W  filtered row data
- in_idx  in  5  producer's row sequence number (0..3·NUM_PIXEL−1)
- abort  in  1  discard the partial fill and restart
- arrays_ack  in  1  consumer finished with the arrays
- a_half_array  out  NUM_PIXEL·ROW_W  packed A rows
- b_half_array  out  NUM_PIXEL·ROW_W  packed B rows
- c_half_array  out  NUM_PIXEL·ROW_W  packed C rows
- arrays_valid  out  1  all arrays complete and stable
- rows_filled  out  5  rows accepted in the current fill
- idx_err  out  1  sticky: some in_idx did not match the expected sequence number

## Operation
- States:
  - FILL: in_ready=1, arrays_valid=0.
  - FULL: in_ready=0, arrays_valid=1.
- Reset state is FILL. While reset is high, every input is ignored.
- Accept: in_valid && in_ready at a rising edge.
  - Let k = rows_filled. Row slot j = k mod NUM_PIXEL.
  - k in 0..7 writes A, 8..15 writes B, 16..23 writes C (for NUM_PIXEL=8).
  - Slot j occupies bits [ROW_W·j + ROW_W−1 : ROW_W·j]. Slot 0 is at the LSBs.
  - rows_filled increments by 1.
- Sequence check: on an accept, if in_idx ≠ rows_filled, set idx_err. The row is still written to slot rows_filled; in_idx never steers the write.
- The accept at k = 3·NUM_PIXEL−1 moves the FSM to FULL.
- FULL + arrays_ack: go to FILL and set rows_filled=0. Array contents are retained until overwritten. idx_err is unchanged.
- abort, in any state: go to FILL, set rows_filled=0, clear idx_err. Array contents are retained. A row presented in the same cycle as abort is not written.
- Priority, highest first: reset > abort > arrays_ack > accept.
- arrays_ack in FILL: ignored.
- in_valid in FULL: not accepted (in_ready=0). The producer must hold the row.
- Reset values:
  - all three arrays 0
  - rows_filled 0
  - arrays_valid 0
  - idx_err 0
  - in_ready 1 from the first cycle after reset deasserts

## Timing
- in_ready and arrays_valid are decoded from the state register. No input reaches them combinationally.
- A row accepted at edge t appears on its array output after edge t (visible in cycle t+1).
- arrays_valid rises in the cycle after the final accept. in_ready falls in that same cycle.
- Minimum fill time is 3·NUM_PIXEL cycles (24) with in_valid held high.
- After arrays_ack at edge t: arrays_valid=0 and in_ready=1 from cycle t+1. Slot 0 of A can be rewritten at edge t+1.
- Back-to-back accepts run at full throughput: one row per cycle with no bubbles inside FILL.

## Test plan
- Full fill: after reset, send 24 rows with in_row = {15{idx[7:0]}} and in_idx = 0..23 back-to-back.
  - Required: arrays_valid rises in cycle 25.
  - Required: a_half_array[119:0]=0x00…, b_half_array slot 0 = {15{8'h08}}, c_half_array slot 7 = {15{8'h17}}.
  - Required: idx_err=0.
- Backpressure: in FULL, hold in_valid=1 with a new row.
  - Required: in_ready=0 and the arrays are unchanged.
  - Then assert arrays_ack. Required: in_ready=1 the next cycle, and the held row lands in A slot 0.
- Sequence error: send in_idx=0,1,3.
  - Required: idx_err=1 after the third accept, and that row is written to A slot 2.
  - Then assert abort. Required: idx_err=0 and rows_filled=0.
- Abort mid-fill: accept 10 rows, then assert abort with in_valid=1.
  - Required: rows_filled=0 and that row is not written.
  - The next accept writes A slot 0. B slot 1 keeps its previous data.
- Priority: in FULL, assert abort and arrays_ack together. Required: FILL, rows_filled=0, idx_err=0.
- Reset mid-fill: reset after 12 accepts. Required: all arrays 0, rows_filled 0, arrays_valid 0.

Source files
------------

// File: rtl/half_pel_row_collector.sv
// Collects filtered 120-bit rows into the A/B/C half-pel arrays and holds the
// completed set stable until the consumer acknowledges it.
module half_pel_row_collector #(
  parameter int NUM_PIXEL = 8,
  parameter int ROW_W     = 120
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROW_W-1:0]           in_row,
  input  logic [4:0]                 in_idx,
  input  logic                       abort,
  input  logic                       arrays_ack,
  output logic [NUM_PIXEL*ROW_W-1:0] a_half_array,
  output logic [NUM_PIXEL*ROW_W-1:0] b_half_array,
  output logic [NUM_PIXEL*ROW_W-1:0] c_half_array,
  output logic                       arrays_valid,
  output logic [4:0]                 rows_filled,
  output logic                       idx_err
);

  localparam int         ARR_W    = NUM_PIXEL * ROW_W;
  localparam logic [4:0] LAST_ROW = 5'(3 * NUM_PIXEL - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       rows_filled_q, rows_filled_d;
  logic             idx_err_q, idx_err_d;
  logic [ARR_W-1:0] a_q, a_d;
  logic [ARR_W-1:0] b_q, b_d;
  logic [ARR_W-1:0] c_q, c_d;

  logic [1:0] bank;
  logic [4:0] slot;
  logic       accept;

  // Map the running row count onto an array (bank) and a slot within it.
  always_comb begin
    bank = 2'd0;
    slot = rows_filled_q;
    if (rows_filled_q >= 5'(2 * NUM_PIXEL)) begin
      bank = 2'd2;
      slot = rows_filled_q - 5'(2 * NUM_PIXEL);
    end else if (rows_filled_q >= 5'(NUM_PIXEL)) begin
      bank = 2'd1;
      slot = rows_filled_q - 5'(NUM_PIXEL);
    end
  end

  assign accept = in_valid && (state_q == FILL) && !abort;

  always_comb begin
    state_d       = state_q;
    rows_filled_d = rows_filled_q;
    idx_err_d     = idx_err_q;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;

    if (abort) begin
      state_d       = FILL;
      rows_filled_d = 5'd0;
      idx_err_d     = 1'b0;
    end else if (state_q == FULL) begin
      if (arrays_ack) begin
        state_d       = FILL;
        rows_filled_d = 5'd0;
      end
    end else if (accept) begin
      // in_idx is only checked; the write position always follows the count.
      for (int s = 0; s < NUM_PIXEL; s++) begin
        if (slot == 5'(s)) begin
          case (bank)
            2'd0:    a_d[s*ROW_W +: ROW_W] = in_row;
            2'd1:    b_d[s*ROW_W +: ROW_W] = in_row;
            default: c_d[s*ROW_W +: ROW_W] = in_row;
          endcase
        end
      end
      if (in_idx != rows_filled_q) begin
        idx_err_d = 1'b1;
      end
      rows_filled_d = rows_filled_q + 5'd1;
      if (rows_filled_q == LAST_ROW) begin
        state_d = FULL;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= FILL;
      rows_filled_q <= 5'd0;
      idx_err_q     <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
    end else begin
      state_q       <= state_d;
      rows_filled_q <= rows_filled_d;
      idx_err_q     <= idx_err_d;
      a_q           <= a_d;
      b_q           <= b_d;
      c_q           <= c_d;
    end
  end

  assign in_ready     = (state_q == FILL);
  assign arrays_valid = (state_q == FULL);
  assign rows_filled  = rows_filled_q;
  assign idx_err      = idx_err_q;
  assign a_half_array = a_q;
  assign b_half_array = b_q;
  assign c_half_array = c_q;

endmodule

// File: tb/tb_half_pel_row_collector.sv
// Bench for half_pel_row_collector: directed scenarios plus random traffic,
// every cycle compared against a flat row-list model of the three arrays.
module tb_half_pel_row_collector;

  localparam int N     = 8;
  localparam int ROW_W = 120;
  localparam int TOTAL = 3 * N;

  logic               clock;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [ROW_W-1:0]   in_row;
  logic [4:0]         in_idx;
  logic               abort;
  logic               arrays_ack;
  logic [N*ROW_W-1:0] a_half_array;
  logic [N*ROW_W-1:0] b_half_array;
  logic [N*ROW_W-1:0] c_half_array;
  logic               arrays_valid;
  logic [4:0]         rows_filled;
  logic               idx_err;

  int errCount;
  int checkCount;

  // Reference: rows stored in arrival order, A = 0..7, B = 8..15, C = 16..23.
  logic [ROW_W-1:0] mem [TOTAL];
  int               mCount;
  bit               mFull;
  bit               mErr;

  half_pel_row_collector #(.NUM_PIXEL(N), .ROW_W(ROW_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_row       (in_row),
    .in_idx       (in_idx),
    .abort        (abort),
    .arrays_ack   (arrays_ack),
    .a_half_array (a_half_array),
    .b_half_array (b_half_array),
    .c_half_array (c_half_array),
    .arrays_valid (arrays_valid),
    .rows_filled  (rows_filled),
    .idx_err      (idx_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [ROW_W-1:0] got,
                             input logic [ROW_W-1:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic modelStep(input bit v, input logic [ROW_W-1:0] row,
                           input logic [4:0] idx, input bit ab, input bit ack,
                           input bit rst);
    if (rst) begin
      mCount = 0;
      mFull  = 0;
      mErr   = 0;
      for (int i = 0; i < TOTAL; i++) mem[i] = '0;
    end else if (ab) begin
      mCount = 0;
      mFull  = 0;
      mErr   = 0;
    end else if (mFull) begin
      if (ack) begin
        mFull  = 0;
        mCount = 0;
      end
    end else if (v) begin
      mem[mCount] = row;
      if (int'(idx) != mCount) mErr = 1;
      mCount++;
      if (mCount == TOTAL) mFull = 1;
    end
  endtask

  task automatic compareAll();
    checkOutput("in_ready", ROW_W'(in_ready), ROW_W'(!mFull));
    checkOutput("arrays_valid", ROW_W'(arrays_valid), ROW_W'(mFull));
    checkOutput("rows_filled", ROW_W'(rows_filled), ROW_W'(mCount));
    checkOutput("idx_err", ROW_W'(idx_err), ROW_W'(mErr));
    for (int j = 0; j < N; j++) begin
      checkOutput($sformatf("a_slot%0d", j), a_half_array[j*ROW_W +: ROW_W], mem[j]);
      checkOutput($sformatf("b_slot%0d", j), b_half_array[j*ROW_W +: ROW_W], mem[N+j]);
      checkOutput($sformatf("c_slot%0d", j), c_half_array[j*ROW_W +: ROW_W], mem[2*N+j]);
    end
  endtask

  // Drive one cycle of inputs, step the model at the edge, compare just after.
  task automatic applyStimulus(input bit v, input logic [ROW_W-1:0] row,
                               input logic [4:0] idx, input bit ab,
                               input bit ack, input bit rst);
    in_valid   = v;
    in_row     = row;
    in_idx     = idx;
    abort      = ab;
    arrays_ack = ack;
    reset      = rst;
    @(posedge clock);
    modelStep(v, row, idx, ab, ack, rst);
    #1;
    compareAll();
  endtask

  function automatic logic [ROW_W-1:0] patRow(input int k);
    logic [7:0] b;
    b = 8'(k);
    return {15{b}};
  endfunction

  function automatic logic [ROW_W-1:0] randRow();
    return {$urandom(), $urandom(), $urandom(), 24'($urandom())};
  endfunction

  logic [ROW_W-1:0] expRow;
  logic [ROW_W-1:0] heldRow;

  initial begin
    errCount   = 0;
    checkCount = 0;
    mCount     = 0;
    mFull      = 0;
    mErr       = 0;
    in_valid   = 0;
    in_row     = '0;
    in_idx     = '0;
    abort      = 0;
    arrays_ack = 0;
    reset      = 1;

    applyStimulus(0, '0, 0, 0, 0, 1);
    applyStimulus(0, '0, 0, 0, 0, 1);
    applyStimulus(0, '0, 0, 0, 0, 0);

    // Full fill with patterned rows, back-to-back.
    for (int k = 0; k < TOTAL; k++) applyStimulus(1, patRow(k), 5'(k), 0, 0, 0);
    checkOutput("fill_valid", ROW_W'(arrays_valid), ROW_W'(1));
    checkOutput("fill_a0", a_half_array[0 +: ROW_W], '0);
    expRow = {15{8'h08}};
    checkOutput("fill_b0", b_half_array[0 +: ROW_W], expRow);
    expRow = {15{8'h17}};
    checkOutput("fill_c7", c_half_array[7*ROW_W +: ROW_W], expRow);
    checkOutput("fill_err", ROW_W'(idx_err), ROW_W'(0));

    // Backpressure: row held in FULL, then acknowledged and accepted.
    heldRow = randRow();
    for (int k = 0; k < 4; k++) applyStimulus(1, heldRow, 0, 0, 0, 0);
    applyStimulus(1, heldRow, 0, 0, 1, 0);
    checkOutput("ack_ready", ROW_W'(in_ready), ROW_W'(1));
    applyStimulus(1, heldRow, 0, 0, 0, 0);
    checkOutput("held_a0", a_half_array[0 +: ROW_W], heldRow);

    // Sequence error: indices 0,1,3 after an abort.
    applyStimulus(0, '0, 0, 1, 0, 0);
    applyStimulus(1, randRow(), 0, 0, 0, 0);
    applyStimulus(1, randRow(), 1, 0, 0, 0);
    heldRow = randRow();
    applyStimulus(1, heldRow, 3, 0, 0, 0);
    checkOutput("seq_err", ROW_W'(idx_err), ROW_W'(1));
    checkOutput("seq_a2", a_half_array[2*ROW_W +: ROW_W], heldRow);
    applyStimulus(0, '0, 0, 1, 0, 0);
    checkOutput("seq_clr", ROW_W'(idx_err), ROW_W'(0));

    // Abort mid-fill with a row presented.
    for (int k = 0; k < 10; k++) applyStimulus(1, randRow(), 5'(k), 0, 0, 0);
    applyStimulus(1, randRow(), 10, 1, 0, 0);
    checkOutput("abort_rows", ROW_W'(rows_filled), ROW_W'(0));
    heldRow = randRow();
    applyStimulus(1, heldRow, 0, 0, 0, 0);
    checkOutput("abort_a0", a_half_array[0 +: ROW_W], heldRow);

    // Abort and ack together in FULL, with a stale error pending.
    applyStimulus(0, '0, 0, 1, 0, 0);
    for (int k = 0; k < TOTAL; k++) applyStimulus(1, randRow(), 5'(k ^ 1), 0, 0, 0);
    applyStimulus(0, '0, 0, 1, 1, 0);
    checkOutput("prio_ready", ROW_W'(in_ready), ROW_W'(1));
    checkOutput("prio_err", ROW_W'(idx_err), ROW_W'(0));

    // Reset mid-fill.
    for (int k = 0; k < 12; k++) applyStimulus(1, randRow(), 5'(k), 0, 0, 0);
    applyStimulus(0, '0, 0, 0, 0, 1);
    checkOutput("rst_b3", b_half_array[3*ROW_W +: ROW_W], '0);
    applyStimulus(0, '0, 0, 0, 0, 0);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      automatic bit v   = ($urandom_range(0, 3) != 0);
      automatic bit ab  = ($urandom_range(0, 39) == 0);
      automatic bit ack = ($urandom_range(0, 2) == 0);
      automatic bit rst = ($urandom_range(0, 149) == 0);
      automatic logic [4:0] idx = ($urandom_range(0, 9) == 0) ?
                                  5'($urandom_range(0, 31)) : 5'(mCount);
      applyStimulus(v, randRow(), idx, ab, ack, rst);
    end

    $display("[TB] Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
